// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op encodings follow funct3 of the M extension.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } mdu_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 step: shift-add multiply or restoring divide.
// acc holds {hi, lo}: product/multiplier or remainder/quotient.
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]}
           + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      // borrow out of the X+1-bit subtract means restore
      if (diff[XLEN])
        acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Sequencer for the shared iterative RV32M mul/div datapath.
// Owns the FSM, iteration count, sign fixup and special-case fast path.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mdu_state_e state_q, state_d;
  mdu_op_e    op_in, op_q;

  logic              s1_q, s2_q;
  logic [XLEN-1:0]   mag2_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              sg1, sg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div0, ovf, spec;
  logic [XLEN-1:0]   spec_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_res;
  logic              is_mul_lo, is_mul_hi;
  logic              is_quo, is_rem;

  logic [2*XLEN-1:0] chain [UNROLL+1];

  assign op_in = mdu_op_e'(op_i);

  assign sg1 = rs1_i[XLEN-1] &
    (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sg2 = rs2_i[XLEN-1] &
    (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});

  // INT_MIN magnitude still fits as an unsigned XLEN value
  assign mag1 = sg1 ? (~rs1_i + 1'b1) : rs1_i;
  assign mag2 = sg2 ? (~rs2_i + 1'b1) : rs2_i;

  assign div0 = op_i[2] & (rs2_i == '0);
  assign ovf  = (op_in == OP_DIV || op_in == OP_REM)
              & (rs1_i == XLEN'(INT_MIN))
              & (rs2_i == '1);
  assign spec = div0 | ovf;

  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = op_i[1] ? rs1_i : XLEN'(DIV_ZERO_Q);
    else if (ovf)
      spec_res = op_i[1] ? '0 : XLEN'(INT_MIN);
  end

  assign chain[0] = acc_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    mdu_iter_step #(
      .XLEN(XLEN)
    ) u_step (
      .is_div (op_q[2]),
      .acc    (chain[g]),
      .opnd   (mag2_q),
      .acc_nxt(chain[g+1])
    );
  end

  assign prod = (s1_q ^ s2_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo  = (s1_q ^ s2_q) ? (~acc_q[XLEN-1:0] + 1'b1)
                              : acc_q[XLEN-1:0];
  assign rem  = s1_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                     : acc_q[2*XLEN-1:XLEN];

  assign is_mul_lo = (op_q == OP_MUL);
  assign is_mul_hi = !op_q[2] && (op_q != OP_MUL);
  assign is_quo    = op_q[2] && !op_q[1];
  assign is_rem    = op_q[2] && op_q[1];

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      is_mul_lo: fix_res = prod[XLEN-1:0];
      is_mul_hi: fix_res = prod[2*XLEN-1:XLEN];
      is_quo:    fix_res = quo;
      is_rem:    fix_res = rem;
      default:   fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i && !flush_i)
              state_d = spec ? DONE : BUSY;
      BUSY: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
    stall_o = !flush_i &&
      ((state_q == IDLE && start_i) ||
       state_q == BUSY || state_q == FIX);
    done_o  = (state_q == DONE) && !flush_i;
    busy_o  = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      mag2_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (!flush_i) begin
      if (state_q == IDLE && start_i) begin
        op_q   <= op_in;
        s1_q   <= sg1;
        s2_q   <= sg2;
        mag2_q <= mag2;
        acc_q  <= {{XLEN{1'b0}}, mag1};
        cnt_q  <= CW'(N - 1);
        if (spec) result_q <= spec_res;
      end
      if (state_q == BUSY) begin
        acc_q <= chain[UNROLL];
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == FIX) result_q <= fix_res;
    end
  end

  assign result_o = result_q;

endmodule
